// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM encoding, counter width and the bit-period derivation.
// TX and RX both import this package, so they always compute the same bit timing.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_START = 2'd1,
        FSM_SEND  = 2'd2,
        FSM_STOP  = 2'd3
    } fsm_state_t;

    localparam int COUNT_REG_LEN = 16;

    // Integer-ns arithmetic: bit period in ns divided by clock period in ns.
    function automatic int cycles_per_bit(input int bit_rate, input int clk_hz);
        return (1000000000 / bit_rate) / (1000000000 / clk_hz);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB first, then STOP_BITS stop bits.
// The start bit appears 1 clk after an accepted request; requests made while busy are dropped.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

    localparam int                       CPB       = cycles_per_bit(BIT_RATE, CLK_HZ);
    localparam logic [COUNT_REG_LEN-1:0] CPB_LAST  = COUNT_REG_LEN'(CPB - 1);
    localparam logic [COUNT_REG_LEN-1:0] STOP_LAST = COUNT_REG_LEN'(STOP_BITS * CPB - 1);
    localparam logic [3:0]               BIT_LAST  = 4'(PAYLOAD_BITS - 1);

    fsm_state_t                 r_state;
    logic [COUNT_REG_LEN-1:0]   r_cycle_cnt;
    logic [3:0]                 r_bit_cnt;
    logic [PAYLOAD_BITS-1:0]    r_sreg;
    logic                       r_txd;

    fsm_state_t                 w_state_nxt;
    logic [COUNT_REG_LEN-1:0]   w_cycle_nxt;
    logic [3:0]                 w_bit_nxt;
    logic [PAYLOAD_BITS-1:0]    w_sreg_nxt;
    logic [PAYLOAD_BITS-1:0]    w_sreg_shift;
    logic                       w_txd_nxt;
    logic                       w_bit_done;

    assign w_bit_done   = (r_cycle_cnt == CPB_LAST);
    assign w_sreg_shift = r_sreg >> 1;

    always_comb begin
        w_state_nxt = r_state;
        w_cycle_nxt = r_cycle_cnt + COUNT_REG_LEN'(1);
        w_bit_nxt   = r_bit_cnt;
        w_sreg_nxt  = r_sreg;
        w_txd_nxt   = r_txd;
        case (r_state)
            FSM_IDLE: begin
                w_cycle_nxt = '0;
                w_bit_nxt   = '0;
                w_txd_nxt   = 1'b1;
                if (uart_tx_en) begin
                    w_state_nxt = FSM_START;
                    w_sreg_nxt  = uart_tx_data;
                    w_txd_nxt   = 1'b0;
                end
            end
            FSM_START: begin
                if (w_bit_done) begin
                    w_state_nxt = FSM_SEND;
                    w_cycle_nxt = '0;
                    w_txd_nxt   = r_sreg[0];
                end
            end
            FSM_SEND: begin
                // The pin is registered, so it loads the bit that the shift exposes next.
                if (w_bit_done) begin
                    w_cycle_nxt = '0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = FSM_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_bit_nxt  = r_bit_cnt + 4'd1;
                        w_sreg_nxt = w_sreg_shift;
                        w_txd_nxt  = w_sreg_shift[0];
                    end
                end
            end
            FSM_STOP: begin
                w_txd_nxt = 1'b1;
                if (r_cycle_cnt == STOP_LAST) begin
                    w_state_nxt = FSM_IDLE;
                    w_cycle_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = FSM_IDLE;
                w_cycle_nxt = '0;
                w_bit_nxt   = '0;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= FSM_IDLE;
            r_cycle_cnt <= '0;
            r_bit_cnt   <= '0;
            r_sreg      <= '0;
            r_txd       <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cycle_cnt <= w_cycle_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_sreg      <= w_sreg_nxt;
            r_txd       <= w_txd_nxt;
        end
    end

    assign uart_txd     = r_txd;
    assign uart_tx_busy = (r_state != FSM_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clks per bit (5 Mbit/s on a 50 MHz clock),
// with an 8N1 instance and a 7N2 instance sharing clock and reset.
module tb_uart_tx;

    localparam int CPB    = 10;
    localparam int FRAME8 = CPB * 10;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       txd, busy;
    logic       en     = 1'b0;
    logic [7:0] data   = 8'h00;
    logic       txd2, busy2;
    logic       en2    = 1'b0;
    logic [6:0] data2  = 7'h00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_txd     (txd),
        .uart_tx_busy (busy),
        .uart_tx_en   (en),
        .uart_tx_data (data)
    );

    uart_tx #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(7), .STOP_BITS(2)) dut2 (
        .clk          (clk),
        .resetn       (resetn),
        .uart_txd     (txd2),
        .uart_tx_busy (busy2),
        .uart_tx_en   (en2),
        .uart_tx_data (data2)
    );

    // Called at a negedge with the 8N1 instance idle; checks every clock of the frame
    // plus the first idle clock. poke_at >= 0 issues a second request (with new data)
    // at that cycle of the frame, which must be ignored.
    task automatic run_frame(input logic [7:0] d, input int poke_at);
        logic [9:0] lvl;
        logic       exp_txd, exp_busy;
        lvl  = {1'b1, d, 1'b0};
        en   = 1'b1;
        data = d;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pre_accept data=%h txd=%b busy=%b expected txd=1 busy=0", d, txd, busy);
        end
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k <= FRAME8; k++) begin
            exp_txd  = (k < FRAME8) ? lvl[k / CPB] : 1'b1;
            exp_busy = (k < FRAME8);
            checks++;
            if (txd !== exp_txd) begin
                errors++;
                $display("FAIL frame_txd data=%h cycle=%0d got=%b expected=%b", d, k, txd, exp_txd);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL frame_busy data=%h cycle=%0d got=%b expected=%b", d, k, busy, exp_busy);
            end
            if (k == poke_at) begin
                en   = 1'b1;
                data = ~d;
            end
            if (k == poke_at + 1) en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || txd2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state txd=%b busy=%b txd2=%b busy2=%b expected 1 0 1 0",
                     txd, busy, txd2, busy2);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset txd=%b busy=%b expected 1 0", txd, busy);
        end
    endtask

    task automatic test_frame_a5();
        run_frame(8'hA5, -1);
    endtask

    task automatic test_patterns();
        run_frame(8'h00, -1);
        run_frame(8'hFF, -1);
        run_frame(8'h81, -1);
        for (int i = 0; i < 4; i++) run_frame(8'($urandom_range(0, 255)), -1);
    endtask

    task automatic test_back_to_back();
        int  rel;
        logic exp_txd, exp_busy;
        en   = 1'b1;
        data = 8'h00;
        @(negedge clk);
        for (int k = 0; k < 3 * (FRAME8 + 1); k++) begin
            rel      = k % (FRAME8 + 1);
            exp_txd  = (rel >= 9 * CPB);
            exp_busy = (rel < FRAME8);
            checks++;
            if (txd !== exp_txd || busy !== exp_busy) begin
                errors++;
                $display("FAIL b2b cycle=%0d txd=%b busy=%b expected txd=%b busy=%b",
                         k, txd, busy, exp_txd, exp_busy);
            end
            if (k == 2 * (FRAME8 + 1) + 50) en = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop txd=%b busy=%b expected 1 0", txd, busy);
        end
    endtask

    task automatic test_busy_ignore();
        run_frame(8'hFF, 30);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (txd !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL dropped_request cycle=%0d txd=%b busy=%b expected 1 0", k, txd, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midframe();
        en   = 1'b1;
        data = 8'h3C;
        @(negedge clk);
        en = 1'b0;
        repeat (4 * CPB + 5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy got=%b expected=1", busy);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset txd=%b busy=%b expected 1 0", txd, busy);
        end
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_reset txd=%b busy=%b expected 1 0", txd, busy);
        end
        resetn = 1'b1;
        @(negedge clk);
        run_frame(8'h3C, -1);
    endtask

    task automatic test_7n2();
        logic [9:0] lvl;
        logic       exp_txd, exp_busy;
        lvl   = {2'b11, 7'h55, 1'b0};
        en2   = 1'b1;
        data2 = 7'h55;
        @(negedge clk);
        en2 = 1'b0;
        for (int k = 0; k <= FRAME8; k++) begin
            exp_txd  = (k < FRAME8) ? lvl[k / CPB] : 1'b1;
            exp_busy = (k < FRAME8);
            checks++;
            if (txd2 !== exp_txd || busy2 !== exp_busy) begin
                errors++;
                $display("FAIL frame_7n2 cycle=%0d txd=%b busy=%b expected txd=%b busy=%b",
                         k, txd2, busy2, exp_txd, exp_busy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_patterns();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midframe();
        test_7n2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
